// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm clock design.
//   bcd_byte_t : two-digit packed BCD value, {tens[7:4], units[3:0]}
//   SEC_MAX    : last legal seconds value (59)
//   MIN_MAX    : last legal minutes value (59)
//   HOUR_MAX   : last legal hours value (23)
//   bcd_next() : next value of a two-digit BCD counter that wraps to 00
//                after a given maximum
// -----------------------------------------------------------------------------
package alarm_pkg;

    typedef logic [7:0] bcd_byte_t;

    localparam bcd_byte_t BCD_ZERO = 8'h00;
    localparam bcd_byte_t SEC_MAX  = 8'h59;
    localparam bcd_byte_t MIN_MAX  = 8'h59;
    localparam bcd_byte_t HOUR_MAX = 8'h23;

    // Successor of a BCD byte. Reaching max_bcd wraps to 00; otherwise the
    // units digit wraps 9->0 and carries into the tens digit. Because the
    // maximum check comes first, the tens digit never needs its own limit
    // (59 and 23 both wrap before the tens digit could overflow).
    function automatic bcd_byte_t bcd_next(input bcd_byte_t value,
                                           input bcd_byte_t max_bcd);
        bcd_byte_t next_v;
        if (value == max_bcd) begin
            next_v = BCD_ZERO;
        end else if (value[3:0] == 4'h9) begin
            next_v = {value[7:4] + 4'h1, 4'h0};
        end else begin
            next_v = {value[7:4], value[3:0] + 4'h1};
        end
        return next_v;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD counter that counts 00..MAX_BCD and wraps to 00.
// Ports:
//   clk   in  1  system clock
//   rst   in  1  synchronous reset, active-high (value -> 00)
//   inc   in  1  advance by one on the next edge
//   clr   in  1  clear to 00 on the next edge (wins over inc)
//   value out 8  registered BCD count
//   wrap  out 1  combinational: inc is asserted while value == MAX_BCD,
//                i.e. this edge rolls the counter back to 00 (carry out)
// -----------------------------------------------------------------------------
import alarm_pkg::*;

module bcd_mod_counter #(
    parameter bcd_byte_t MAX_BCD = SEC_MAX
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      inc,
    input  logic      clr,
    output bcd_byte_t value,
    output logic      wrap
);

    bcd_byte_t value_r;
    logic      wrap_s;

    // Count register: reset, clear, increment or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_r <= BCD_ZERO;
        end else if (clr) begin
            value_r <= BCD_ZERO;
        end else if (inc) begin
            value_r <= bcd_next(value_r, MAX_BCD);
        end else begin
            value_r <= value_r;
        end
    end

    // Carry out: left combinational so a cascade of counters resolves on one edge.
    always_comb begin
        wrap_s = 1'b0;
        if (inc && (value_r == MAX_BCD)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    assign value = value_r;
    assign wrap  = wrap_s;

endmodule

// File: rtl/tod_counter.sv
// -----------------------------------------------------------------------------
// tod_counter
// Time-of-day keeper: divides clk down to a 1 Hz tick and keeps a 24-hour
// hh:mm:ss count in BCD. A set mode lets debounced buttons adjust hours and
// minutes while timekeeping is paused.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  synchronous reset, active-high; overrides everything
//   ena      in  1  design enable; low freezes all state, strobes read 0
//   set_en   in  1  level; high = set mode (prescaler and seconds held at 0)
//   inc_hour in  1  pulse; hours +1 (23 -> 00) while in set mode
//   inc_min  in  1  pulse; minutes +1 (59 -> 00, no hour carry) in set mode
//   hours    out 8  BCD hours 00..23
//   minutes  out 8  BCD minutes 00..59
//   seconds  out 8  BCD seconds 00..59
//   sec_tick out 1  one-cycle strobe, aligned with each seconds advance
//   min_roll out 1  one-cycle strobe when seconds wrap 59 -> 00
//   day_roll out 1  one-cycle strobe when 23:59:59 -> 00:00:00
// -----------------------------------------------------------------------------
import alarm_pkg::*;

module tod_counter #(
    parameter int TICK_DIV   = 10000000,
    parameter int PRESCALE_W = 24
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      ena,
    input  logic      set_en,
    input  logic      inc_hour,
    input  logic      inc_min,
    output bcd_byte_t hours,
    output bcd_byte_t minutes,
    output bcd_byte_t seconds,
    output logic      sec_tick,
    output logic      min_roll,
    output logic      day_roll
);

    localparam logic [PRESCALE_W-1:0] PRE_ZERO = {PRESCALE_W{1'b0}};
    localparam logic [PRESCALE_W-1:0] PRE_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(TICK_DIV - 1);

    logic [PRESCALE_W-1:0] prescale_r;

    logic run_s;
    logic set_s;
    logic tick_s;

    logic sec_inc_s;
    logic sec_clr_s;
    logic min_inc_s;
    logic hour_inc_s;

    logic sec_wrap_s;
    logic min_wrap_s;
    logic hour_wrap_s;

    logic sec_tick_r;
    logic min_roll_r;
    logic day_roll_r;

    bcd_byte_t seconds_s;
    bcd_byte_t minutes_s;
    bcd_byte_t hours_s;

    // Mode decode: ena low leaves both modes inactive, so everything holds.
    always_comb begin
        run_s = 1'b0;
        set_s = 1'b0;
        if (ena) begin
            run_s = ~set_en;
            set_s = set_en;
        end else begin
            run_s = 1'b0;
            set_s = 1'b0;
        end
    end

    // One-second tick: last prescaler count while running. Never asserted in
    // set mode, which is what discards a tick landing on the set_en rising cycle.
    always_comb begin
        tick_s = 1'b0;
        if (run_s && (prescale_r == PRE_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Prescaler: counts 0..TICK_DIV-1 in run mode, parked at 0 in set mode so
    // leaving set mode always starts a full second.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_r <= PRE_ZERO;
        end else if (!ena) begin
            prescale_r <= prescale_r;
        end else if (set_en) begin
            prescale_r <= PRE_ZERO;
        end else if (tick_s) begin
            prescale_r <= PRE_ZERO;
        end else begin
            prescale_r <= prescale_r + PRE_ONE;
        end
    end

    // Seconds control: advance on the tick, forced to 00 throughout set mode.
    always_comb begin
        sec_inc_s = 1'b0;
        sec_clr_s = 1'b0;
        if (run_s) begin
            sec_inc_s = tick_s;
            sec_clr_s = 1'b0;
        end else if (set_s) begin
            sec_inc_s = 1'b0;
            sec_clr_s = 1'b1;
        end else begin
            sec_inc_s = 1'b0;
            sec_clr_s = 1'b0;
        end
    end

    // Minutes advance on the seconds carry when running, on the button when setting.
    always_comb begin
        min_inc_s = 1'b0;
        if (run_s) begin
            min_inc_s = sec_wrap_s;
        end else if (set_s) begin
            min_inc_s = inc_min;
        end else begin
            min_inc_s = 1'b0;
        end
    end

    // Hours advance on the minutes carry when running, on the button when setting.
    // In set mode the minutes wrap is deliberately not used, so no carry.
    always_comb begin
        hour_inc_s = 1'b0;
        if (run_s) begin
            hour_inc_s = min_wrap_s;
        end else if (set_s) begin
            hour_inc_s = inc_hour;
        end else begin
            hour_inc_s = 1'b0;
        end
    end

    bcd_mod_counter #(
        .MAX_BCD (SEC_MAX)
    ) u_seconds (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc_s),
        .clr   (sec_clr_s),
        .value (seconds_s),
        .wrap  (sec_wrap_s)
    );

    bcd_mod_counter #(
        .MAX_BCD (MIN_MAX)
    ) u_minutes (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc_s),
        .clr   (1'b0),
        .value (minutes_s),
        .wrap  (min_wrap_s)
    );

    bcd_mod_counter #(
        .MAX_BCD (HOUR_MAX)
    ) u_hours (
        .clk   (clk),
        .rst   (rst),
        .inc   (hour_inc_s),
        .clr   (1'b0),
        .value (hours_s),
        .wrap  (hour_wrap_s)
    );

    // Strobe registers: sampled alongside the counters so each strobe lines up
    // with the updated time; zero outside run mode (set mode or ena low).
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_tick_r <= 1'b0;
            min_roll_r <= 1'b0;
            day_roll_r <= 1'b0;
        end else if (run_s) begin
            sec_tick_r <= tick_s;
            min_roll_r <= sec_wrap_s;
            day_roll_r <= hour_wrap_s;
        end else begin
            sec_tick_r <= 1'b0;
            min_roll_r <= 1'b0;
            day_roll_r <= 1'b0;
        end
    end

    assign hours    = hours_s;
    assign minutes  = minutes_s;
    assign seconds  = seconds_s;
    assign sec_tick = sec_tick_r;
    assign min_roll = min_roll_r;
    assign day_roll = day_roll_r;

endmodule

// File: tb/tb_tod_counter.sv
module tb_tod_counter;

    localparam int TD = 4;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       set_en;
    logic       inc_hour;
    logic       inc_min;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       sec_tick;
    logic       min_roll;
    logic       day_roll;

    int total = 0;
    int bad   = 0;

    // behavioural model: time of day as plain seconds since midnight
    int m_tod   = 0;
    int m_pre   = 0;
    int m_hh    = 0;
    int m_mm    = 0;
    bit m_tick  = 1'b0;
    bit m_mroll = 1'b0;
    bit m_droll = 1'b0;
    bit m_valid = 1'b0;

    bit watch_set     = 1'b0;
    int set_tick_cnt  = 0;

    tod_counter #(
        .TICK_DIV   (TD),
        .PRESCALE_W (24)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .set_en   (set_en),
        .inc_hour (inc_hour),
        .inc_min  (inc_min),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .sec_tick (sec_tick),
        .min_roll (min_roll),
        .day_roll (day_roll)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [7:0] v, input int lim);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return 1'b0;
        return (int'(v[7:4]) * 10 + int'(v[3:0])) <= lim;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model update on every active edge
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_tod = 0; m_pre = 0;
                m_tick = 1'b0; m_mroll = 1'b0; m_droll = 1'b0;
            end else if (!ena) begin
                m_tick = 1'b0; m_mroll = 1'b0; m_droll = 1'b0;
            end else if (set_en) begin
                m_hh = m_tod / 3600;
                m_mm = (m_tod / 60) % 60;
                if (inc_min)  m_mm = (m_mm + 1) % 60;
                if (inc_hour) m_hh = (m_hh + 1) % 24;
                m_tod = m_hh * 3600 + m_mm * 60;
                m_pre = 0;
                m_tick = 1'b0; m_mroll = 1'b0; m_droll = 1'b0;
            end else if (m_pre == TD - 1) begin
                m_pre   = 0;
                m_tod   = (m_tod + 1) % 86400;
                m_tick  = 1'b1;
                m_mroll = (m_tod % 60) == 0;
                m_droll = (m_tod == 0);
            end else begin
                m_pre = m_pre + 1;
                m_tick = 1'b0; m_mroll = 1'b0; m_droll = 1'b0;
            end
            m_valid = 1'b1;
        end
    end

    // per-cycle compare against the model, plus BCD range checks
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("m_hours",   hours,    to_bcd(m_tod / 3600));
                chk("m_minutes", minutes,  to_bcd((m_tod / 60) % 60));
                chk("m_seconds", seconds,  to_bcd(m_tod % 60));
                chk("m_sec_tick", sec_tick, m_tick);
                chk("m_min_roll", min_roll, m_mroll);
                chk("m_day_roll", day_roll, m_droll);
                chk("range", {bcd_ok(hours, 23), bcd_ok(minutes, 59), bcd_ok(seconds, 59)}, 3'b111);
                if (watch_set && sec_tick) set_tick_cnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit h, input bit m);
        inc_hour = h;
        inc_min  = m;
        step(1);
        inc_hour = 1'b0;
        inc_min  = 1'b0;
        step(1);
    endtask

    int cnt_a;
    int cnt_b;
    int first_tick;

    initial begin
        rst = 1'b1; ena = 1'b1; set_en = 1'b0; inc_hour = 1'b0; inc_min = 1'b0;
        step(2);
        chk("rst_time", {hours, minutes, seconds}, 24'h000000);
        chk("rst_strobes", {sec_tick, min_roll, day_roll}, 3'b000);
        rst = 1'b0;

        // 1: tick every 4th cycle, 00:00:03 after 12 cycles
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("t1_tick_pos", sec_tick, (i % 4) == 3);
        end
        chk("t1_seconds", seconds, 8'h03);
        chk("t1_hm", {hours, minutes}, 16'h0000);
        chk("t1_model_pin", m_tod, 3);

        // 2: clear seconds via set mode, run to 00:00:58, then roll the minute
        set_en = 1'b1;
        step(1);
        set_en = 1'b0;
        chk("t2_cleared", {hours, minutes, seconds}, 24'h000000);
        step(58 * TD);
        chk("t2_at58", {hours, minutes, seconds}, 24'h000058);
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 2 * TD; i++) begin
            step(1);
            if (min_roll) cnt_a++;
            if (min_roll && !sec_tick) cnt_b++;
        end
        chk("t2_time", {hours, minutes, seconds}, 24'h000100);
        chk("t2_mroll_cnt", cnt_a, 1);
        chk("t2_mroll_alone", cnt_b, 0);
        chk("t2_model_pin", m_tod, 60);

        // 3: 23:59:59 -> 00:00:00
        set_en = 1'b1;
        repeat (23) pulse(1'b1, 1'b0);
        repeat (58) pulse(1'b0, 1'b1);
        chk("t3_set", {hours, minutes, seconds}, 24'h235900);
        set_en = 1'b0;
        step(59 * TD);
        chk("t3_at_end", {hours, minutes, seconds}, 24'h235959);
        step(TD - 1);
        chk("t3_pre_roll", {sec_tick, min_roll, day_roll}, 3'b000);
        step(1);
        chk("t3_midnight", {hours, minutes, seconds}, 24'h000000);
        chk("t3_roll", {sec_tick, min_roll, day_roll}, 3'b111);
        step(1);
        chk("t3_roll_once", {min_roll, day_roll}, 2'b00);

        // 4: set mode with 25 hour and 61 minute pulses
        set_en = 1'b1;
        step(1);
        watch_set = 1'b1;
        repeat (25) pulse(1'b1, 1'b0);
        repeat (61) pulse(1'b0, 1'b1);
        watch_set = 1'b0;
        step(1);
        chk("t4_time", {hours, minutes, seconds}, 24'h010100);
        chk("t4_no_tick", set_tick_cnt, 0);

        // 5: simultaneous pulses 09:09 -> 10:10, then full second after release
        repeat (8) pulse(1'b1, 1'b1);
        chk("t5_0909", {hours, minutes}, 16'h0909);
        pulse(1'b1, 1'b1);
        chk("t5_1010", {hours, minutes, seconds}, 24'h101000);
        set_en = 1'b0;
        first_tick = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (sec_tick) begin
                first_tick = k;
                break;
            end
        end
        chk("t5_first_tick", first_tick, TD);

        // 6: reset while ena=0 at 12:34:56, then frozen
        set_en = 1'b1;
        repeat (2) pulse(1'b1, 1'b0);
        repeat (24) pulse(1'b0, 1'b1);
        set_en = 1'b0;
        step(56 * TD);
        chk("t6_at", {hours, minutes, seconds}, 24'h123456);
        ena = 1'b0;
        rst = 1'b1;
        step(1);
        chk("t6_reset", {hours, minutes, seconds}, 24'h000000);
        chk("t6_reset_strobes", {sec_tick, min_roll, day_roll}, 3'b000);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("t6_frozen", {hours, minutes, seconds, sec_tick, min_roll, day_roll}, 27'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tod_counter.md
Name: tod_counter

Overview:
- Time-of-day keeper for the alarm design: divides the system clock into a 1 Hz tick and maintains a 24-hour hh:mm:ss count in BCD.
- Sits directly upstream of the alarm comparator/top. The comparator consumes hours/minutes and the minute-rollover strobe to evaluate the alarm once per minute.
- Provides a set mode, driven by debounced button pulses, for adjusting hours and minutes.

Parameters:
TICK_DIV, 10000000, clk cycles per second; must be >= 2. Benches use 4.
PRESCALE_W, 24, prescaler width; must satisfy 2**PRESCALE_W >= TICK_DIV.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ena  in  1  design enable; low freezes all state
set_en  in  1  level; high = set mode, timekeeping paused
inc_hour  in  1  single-cycle pulse; hours +1 while set_en
inc_min  in  1  single-cycle pulse; minutes +1 while set_en
hours  out  8  BCD hours, {tens[7:4], units[3:0]}, range 00..23
minutes  out  8  BCD minutes, range 00..59
seconds  out  8  BCD seconds, range 00..59
sec_tick  out  1  one-cycle strobe on each seconds advance
min_roll  out  1  one-cycle strobe when seconds wrap 59->00
day_roll  out  1  one-cycle strobe when 23:59:59 -> 00:00:00

Behaviour:
- All outputs are registered. Reset value is 0 for every output, which gives time 00:00:00 and no strobes. The prescaler also resets to 0.
- rst takes priority over everything, including ena. Reset mid-count or mid-set clears state at the next clk edge.
- ena low: the prescaler, counters and set handling all hold. Strobes are forced 0.

Run mode (set_en=0, ena=1):
- The prescaler counts 0..TICK_DIV-1.
- When the prescaler equals TICK_DIV-1:
  - it wraps to 0;
  - seconds advance on that same edge;
  - sec_tick is 1 for the following cycle, aligned with the updated seconds value.
- Cascade:
  - seconds 59->00 carries into minutes and asserts min_roll.
  - minutes 59->00 carries into hours.
  - hours 23->00 with a minute carry asserts day_roll.
  - All carries resolve in the same edge, so there is no ripple latency.
- BCD units wrap 9->0 with a carry into tens.
  - Seconds and minutes tens wrap after 5.
  - Hours wrap at 23, not 29.
- inc_hour and inc_min are ignored in run mode.

Set mode (set_en=1, ena=1):
- The prescaler is held at 0 and seconds are held at 00.
- sec_tick, min_roll and day_roll are 0.
- inc_min: minutes +1 with wrap 59->00 and no carry into hours.
- inc_hour: hours +1 with wrap 23->00.
- Both pulses in the same cycle: both apply independently.
- On the set_en 1->0 edge, run resumes with a full TICK_DIV-cycle second before the first tick.

Entering set mode:
- On the rising set_en cycle, seconds clear to 00 and the prescaler clears on that edge.
- An in-flight tick on the same cycle is discarded.

Illegal states:
- Out-of-range BCD cannot occur from reset. No recovery logic is required.
- Assertions in the bench check range on every cycle.

Decomposition:
- Shared package alarm_pkg holds:
  - the BCD byte type;
  - constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23.
- Sub-module bcd_mod_counter, instantiated three times.
  - Parameter: MAX_BCD.
  - Inputs: inc, clr.
  - Outputs: value, wrap (combinational, asserted when inc && value==MAX_BCD).
- tod_counter contains the prescaler, the set-mode logic and the strobe registers.

Test Plan (TICK_DIV=4):
1. Reset then run 12 cycles -> sec_tick pulses every 4th cycle; seconds reads 8'h03 after 12 cycles; all other outputs 00.
2. Force state to 00:00:58 via set mode plus 58 ticks, then 2 ticks -> seconds 8'h00, minutes 8'h01; min_roll high for exactly 1 cycle, coincident with sec_tick.
3. Reach 23:59:59 (hours set to 23, minutes to 59, run 59 s), then 1 tick -> 00:00:00; day_roll and min_roll both high for 1 cycle.
4. set_en=1 with 25 inc_hour pulses and 61 inc_min pulses -> hours 8'h01, minutes 8'h01, seconds 8'h00; no sec_tick asserted during set mode.
5. inc_hour and inc_min asserted together at 09:09 in set mode -> 10:10; then release set_en -> first sec_tick exactly 4 cycles later.
6. rst asserted mid-count at 12:34:56 while ena=0 -> all outputs 00 on the next edge; with ena=0 held, 20 cycles produce no change and no strobes.
